// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator car and the elevator FSM that commands it.
package elevator_pkg;

    localparam logic [1:0] DIR_STAY  = 2'b00;
    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;

    localparam logic [1:0] FLOOR_MIN = 2'd0;
    localparam logic [1:0] FLOOR_MAX = 2'd3;

    typedef enum logic [1:0] {
        CAR_PARKED      = 2'd0,
        CAR_MOVING_UP   = 2'd1,
        CAR_MOVING_DOWN = 2'd2,
        CAR_DOOR        = 2'd3
    } car_state_e;

    typedef struct packed {
        car_state_e  state;
        logic [7:0]  travel_count;
        logic [7:0]  door_count;
    } car_debug_t;

endpackage

// File: rtl/cycle_timer.sv
// Loadable 8-bit down-counter that parks at zero; zero flag comes straight off the register.
module cycle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       dec,
    input  logic [7:0] load_value,
    output logic [7:0] count,
    output logic       zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/elevator_car.sv
// Single elevator car: travels one floor per command, then holds the door open.
// Moore machine; every output is a register, and the state is mirrored on the debug port.
module elevator_car
    import elevator_pkg::*;
#(
    parameter int unsigned TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] direction,
    output logic [1:0] current_floor,
    output logic       moving,
    output logic       door_open,
    output logic       arrived,
    output logic       limit_hit,
    output car_debug_t debug
);

    localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYCLES - 1);
    localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES - 1);

    car_state_e state;

    logic       parked;
    logic       in_motion;
    logic       go_up;
    logic       go_down;
    logic       blocked;
    logic       travel_load;
    logic       travel_dec;
    logic       door_load;
    logic       door_dec;
    logic [7:0] travel_count;
    logic [7:0] door_count;
    logic       travel_zero;
    logic       door_zero;

    // direction is only looked at while parked, so a mid-trip change has no effect
    always_comb begin
        parked      = (state == CAR_PARKED);
        in_motion   = (state == CAR_MOVING_UP) || (state == CAR_MOVING_DOWN);
        go_up       = parked && (direction == DIR_UP)   && (current_floor != FLOOR_MAX);
        go_down     = parked && (direction == DIR_DOWN) && (current_floor != FLOOR_MIN);
        blocked     = parked && (((direction == DIR_UP)   && (current_floor == FLOOR_MAX)) ||
                                 ((direction == DIR_DOWN) && (current_floor == FLOOR_MIN)));
        travel_load = go_up || go_down;
        travel_dec  = in_motion && !travel_zero;
        door_load   = in_motion && travel_zero;
        door_dec    = (state == CAR_DOOR) && !door_zero;
    end

    cycle_timer u_travel_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (travel_load),
        .dec        (travel_dec),
        .load_value (TRAVEL_LOAD),
        .count      (travel_count),
        .zero       (travel_zero)
    );

    cycle_timer u_door_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (door_load),
        .dec        (door_dec),
        .load_value (DOOR_LOAD),
        .count      (door_count),
        .zero       (door_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= CAR_PARKED;
            current_floor <= FLOOR_MIN;
            moving        <= 1'b0;
            door_open     <= 1'b0;
            arrived       <= 1'b0;
            limit_hit     <= 1'b0;
        end else begin
            arrived   <= 1'b0;
            limit_hit <= 1'b0;
            case (state)
                CAR_PARKED: begin
                    if (go_up) begin
                        state  <= CAR_MOVING_UP;
                        moving <= 1'b1;
                    end else if (go_down) begin
                        state  <= CAR_MOVING_DOWN;
                        moving <= 1'b1;
                    end else if (blocked) begin
                        limit_hit <= 1'b1;
                    end
                end
                CAR_MOVING_UP, CAR_MOVING_DOWN: begin
                    // floor guards at departure keep this 2-bit step from wrapping
                    if (travel_zero) begin
                        current_floor <= (state == CAR_MOVING_UP) ? current_floor + 2'd1
                                                                  : current_floor - 2'd1;
                        state     <= CAR_DOOR;
                        moving    <= 1'b0;
                        door_open <= 1'b1;
                        arrived   <= 1'b1;
                    end
                end
                CAR_DOOR: begin
                    if (door_zero) begin
                        state     <= CAR_PARKED;
                        door_open <= 1'b0;
                    end
                end
                default: begin
                    state <= CAR_PARKED;
                end
            endcase
        end
    end

    assign debug = '{state: state, travel_count: travel_count, door_count: door_count};

endmodule

// File: tb/tb_elevator_car.sv
// Bench for elevator_car: table-driven trips, limit and reset sequences, then a random soak.
module tb_elevator_car;
  import elevator_pkg::*;

  localparam int TRAVEL = 8;
  localparam int DOOR   = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] direction;
  logic [1:0] current_floor;
  logic       moving;
  logic       door_open;
  logic       arrived;
  logic       limit_hit;
  car_debug_t debug;

  elevator_car #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .direction     (direction),
    .current_floor (current_floor),
    .moving        (moving),
    .door_open     (door_open),
    .arrived       (arrived),
    .limit_hit     (limit_hit),
    .debug         (debug)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected output word: {floor[1:0], moving, door_open, arrived, limit_hit}
  typedef struct {
    logic [1:0] dir;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] exp_q[$];
  int         n_checks;
  int         n_fail;
  int         n_prints;

  task automatic add(input logic [1:0] dir, input logic [1:0] fl, input logic mv,
                     input logic dr, input logic ar, input logic lh, input int n,
                     input string name);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.dir  = dir;
      v.exp  = {fl, mv, dr, ar, lh};
      v.name = name;
      vecs.push_back(v);
    end
  endtask

  // one complete floor-to-floor trip with the command held throughout
  task automatic trip(input logic [1:0] dir, input logic [1:0] from_fl,
                      input logic [1:0] to_fl, input string name);
    add(dir, from_fl, 1'b1, 1'b0, 1'b0, 1'b0, TRAVEL,   {name, "_move"});
    add(dir, to_fl,   1'b0, 1'b1, 1'b1, 1'b0, 1,        {name, "_arrive"});
    add(dir, to_fl,   1'b0, 1'b1, 1'b0, 1'b0, DOOR - 1, {name, "_door"});
    add(dir, to_fl,   1'b0, 1'b0, 1'b0, 1'b0, 1,        {name, "_park"});
  endtask

  // scoreboard
  task automatic check_out(input string name);
    logic [5:0] got;
    logic [5:0] exp;
    got = {current_floor, moving, door_open, arrived, limit_hit};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %b", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s: got {floor,mv,door,arr,lim}=%b required %b", name, got, exp);
      end
    end
  endtask

  task automatic check_idle_debug(input string name);
    n_checks++;
    if (debug.state !== CAR_PARKED || debug.travel_count !== 8'd0 || debug.door_count !== 8'd0) begin
      n_fail++;
      $display("FAIL %s: got state=%0d travel=%0d door=%0d required 0 0 0",
               name, debug.state, debug.travel_count, debug.door_count);
    end
  endtask

  // driver
  task automatic run_vecs();
    foreach (vecs[i]) begin
      direction = vecs[i].dir;
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      check_out(vecs[i].name);
    end
    vecs.delete();
  endtask

  task automatic soak(input int cycles);
    logic [1:0] prev_floor;
    int         d;
    bit         ok;
    prev_floor = current_floor;
    for (int i = 0; i < cycles; i++) begin
      direction = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      n_checks++;
      if (moving && door_open) begin
        n_fail++;
        if (n_prints < 20) $display("FAIL soak_overlap: got moving=1 door_open=1 required not both");
        n_prints++;
      end
      d  = int'(current_floor) - int'(prev_floor);
      ok = (d >= -1) && (d <= 1) && (arrived == (d != 0));
      n_checks++;
      if (!ok) begin
        n_fail++;
        if (n_prints < 20)
          $display("FAIL soak_arrival: got floor %0d->%0d arrived=%0b required single step with one arrived pulse",
                   prev_floor, current_floor, arrived);
        n_prints++;
      end
      prev_floor = current_floor;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    n_prints  = 0;
    rst_n     = 1'b0;
    direction = DIR_STAY;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(6'b0);
    check_out("reset_outputs");
    check_idle_debug("reset_debug");
    rst_n = 1'b1;

    // first edge after release acts on the command; departure, arrival, door, re-departure
    trip(DIR_UP, 2'd0, 2'd1, "r27");
    // reversal ignored mid-travel: flip to down on travel cycle 3
    add(DIR_UP,   2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2,          "r30_depart");
    add(DIR_DOWN, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, TRAVEL - 2, "r30_flip");
    add(DIR_DOWN, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1,          "r30_arrive");
    add(DIR_DOWN, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, DOOR - 1,   "r30_door");
    add(DIR_DOWN, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1,          "r30_park");
    trip(DIR_DOWN, 2'd2, 2'd1, "r30_descend");
    add(DIR_STAY, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2, "stay");
    add(2'b11,    2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2, "dir11_stay");
    trip(DIR_UP, 2'd1, 2'd2, "up12");
    trip(DIR_UP, 2'd2, 2'd3, "up23");
    add(DIR_UP,   2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3, "r28_limit");
    add(DIR_STAY, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1, "r28_release");
    trip(DIR_DOWN, 2'd3, 2'd2, "dn32");
    trip(DIR_DOWN, 2'd2, 2'd1, "dn21");
    trip(DIR_DOWN, 2'd1, 2'd0, "dn10");
    add(DIR_DOWN, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3, "r29_limit");
    trip(DIR_UP, 2'd0, 2'd1, "r29_ascend");
    // up to floor 2 and stop in the second door cycle
    add(DIR_UP, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, TRAVEL, "r31_move");
    add(DIR_UP, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1,      "r31_arrive");
    add(DIR_UP, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1,      "r31_door");
    run_vecs();

    // asynchronous reset mid-cycle with the door open
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(6'b0);
    check_out("r31_async_reset");
    check_idle_debug("r31_async_debug");
    @(posedge clk);
    #1;
    exp_q.push_back(6'b0);
    check_out("r31_held_reset");
    rst_n = 1'b1;
    trip(DIR_UP, 2'd0, 2'd1, "r31_restart");
    run_vecs();

    soak(10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_car.md
ELEVATOR_CAR -- requirements
Module: elevator_car

Interface
REQ-001 Parameter TRAVEL_CYCLES, default 8: clock cycles the car spends moving between adjacent floors (legal range 1..255).
REQ-002 Parameter DOOR_CYCLES, default 4: clock cycles the door stays open after arrival (legal range 1..255).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 direction  input  2  motion command from the elevator FSM: 00 stay, 01 up, 10 down, 11 treated as stay.
REQ-006 current_floor  output  2  registered car position, 0..3, fed back to the elevator FSM.
REQ-007 moving  output  1  high while the car travels between floors.
REQ-008 door_open  output  1  high while the door is open at a floor.
REQ-009 arrived  output  1  one-cycle pulse on the first cycle at a new floor.
REQ-010 limit_hit  output  1  one-cycle pulse when a command would drive the car past floor 0 or floor 3.

Function
REQ-011 The block SHALL be a Moore machine with states PARKED, MOVING_UP, MOVING_DOWN and DOOR; all outputs SHALL be registered.
REQ-012 In PARKED, direction 01 with current_floor<3 SHALL enter MOVING_UP next cycle, and direction 10 with current_floor>0 SHALL enter MOVING_DOWN next cycle, loading the travel counter with TRAVEL_CYCLES-1.
REQ-013 In PARKED, direction 01 at floor 3 or 10 at floor 0 SHALL keep PARKED and pulse limit_hit for one cycle, repeating each cycle the command persists.
REQ-014 In PARKED, direction 00 or 11 SHALL keep PARKED with no output change.
REQ-015 direction SHALL be sampled only in PARKED; changes while in MOVING_* or DOOR SHALL be ignored (no reversal mid-travel).
REQ-016 moving SHALL be high for exactly TRAVEL_CYCLES cycles per trip; the travel counter decrements each MOVING cycle.
REQ-017 When the travel counter is 0 in MOVING_*, the next cycle SHALL update current_floor by +1 (up) or -1 (down), assert arrived for one cycle, enter DOOR and load the door counter with DOOR_CYCLES-1.
REQ-018 door_open SHALL be high for exactly DOOR_CYCLES cycles, then the state returns to PARKED; arrived and door_open rise in the same cycle.
REQ-019 current_floor SHALL never wrap; floor arithmetic is 2-bit, guarded by REQ-012/REQ-013.
REQ-020 moving and door_open SHALL never be high simultaneously.
REQ-021 Minimum command-to-next-departure period SHALL be TRAVEL_CYCLES+DOOR_CYCLES+1 cycles.

Reset
REQ-022 rst_n low SHALL immediately force state PARKED, current_floor 0, both counters 0, and moving, door_open, arrived, limit_hit 0, regardless of activity in progress.
REQ-023 Reset asserted mid-travel or with door open SHALL abandon the trip; the car restarts at floor 0.
REQ-024 After rst_n deassertion, the first rising edge SHALL evaluate PARKED transitions normally.

Structure
REQ-025 Package elevator_pkg SHALL hold direction codes (DIR_STAY, DIR_UP, DIR_DOWN), FLOOR_MIN=0, FLOOR_MAX=3 and the car state encoding, shared with the elevator FSM.
REQ-026 One sub-module, cycle_timer (loadable 8-bit down-counter with zero flag), SHALL be instantiated twice: travel and door timing.

Verification (TRAVEL_CYCLES=8, DOOR_CYCLES=4)
REQ-027 Reset, then direction=01 held -> moving high cycles 1-8, floor 0->1 at cycle 9 with arrived pulse, door_open cycles 9-12, departure toward floor 2 at cycle 14.
REQ-028 At floor 3, direction=01 for 3 cycles -> limit_hit pulses 3 cycles, current_floor stays 3, moving stays 0.
REQ-029 At floor 0, direction=10 -> limit_hit each cycle; then direction=01 -> normal ascent to floor 1.
REQ-030 Moving up from floor 1, direction flips to 10 at travel cycle 3 -> car still arrives at floor 2, then descends on next PARKED.
REQ-031 rst_n low for 1 cycle during door open at floor 2 -> outputs immediately 0, current_floor 0, next command obeyed from floor 0.
REQ-032 Random direction over 10k cycles -> moving&door_open never both 1, current_floor always 0..3, each floor change accompanied by exactly one arrived pulse.
